// File: rtl/sha3_pkg.sv
// ----------------------------------------------------------------------------
// sha3_pkg
// Shared constants and types for the SHA-3 datapath blocks.
//   STATE_SIZE  : Keccak-f[1600] state width in bits
//   Z_WIDTH     : lane / input word width in bits
//   PAD_FIRST   : SHA-3 domain suffix byte (0x06) placed right after the message
//   PAD_LAST    : closing pad bit (0x80) placed in the last byte of the rate
//   pad_state_t : padding unit control states
//   clamp_bytes : limits a byte count to the 8 bytes a word can carry
// ----------------------------------------------------------------------------
package sha3_pkg;

    localparam int         STATE_SIZE = 1600;
    localparam int         Z_WIDTH    = 64;
    localparam logic [7:0] PAD_FIRST  = 8'h06;
    localparam logic [7:0] PAD_LAST   = 8'h80;

    typedef enum logic [2:0] {
        FILL      = 3'd0,
        SEND      = 3'd1,
        PAD_BLOCK = 3'd2,
        WAIT_PERM = 3'd3,
        WAIT_HASH = 3'd4
    } pad_state_t;

    function automatic logic [3:0] clamp_bytes(input logic [3:0] nbytes);
        return (nbytes > 4'd8) ? 4'd8 : nbytes;
    endfunction

endpackage

// File: rtl/padding_module.sv
// ----------------------------------------------------------------------------
// padding_module
// Collects 64-bit message words into one rate-sized block, applies SHA-3
// padding (0x06 ... 0x80) on the final word and hands each block to the
// permutation as a one-cycle strobe.
//
// Ports:
//   CLK, A_RST               clock, asynchronous active-high reset
//   CE                       clock enable, freezes all state when low
//   DATA_IN[0:63]            message word, byte j at [8j:8j+7]
//   DATA_VALID/LAST/BYTES    word qualifiers (BYTES used on the last word only)
//   DATA_READY               word accepted this cycle when DATA_VALID=1
//   PERMUTATION_PROCESSING   permutation busy, blocks the next strobe
//   HASH_VALID               digest ready, releases the unit after the last block
//   BLOCK_OUT[0:R-1]         registered padded block, byte k at [8k:8k+7]
//   BLOCK_VALID, BLOCK_LAST  block strobe and final-block qualifier
// ----------------------------------------------------------------------------
module padding_module
    import sha3_pkg::*;
#(
    parameter int R_BLOCK_SIZE = 1152
) (
    input  logic                    CLK,
    input  logic                    A_RST,
    input  logic                    CE,
    input  logic [0:63]             DATA_IN,
    input  logic                    DATA_VALID,
    input  logic                    DATA_LAST,
    input  logic [3:0]              DATA_BYTES,
    output logic                    DATA_READY,
    input  logic                    PERMUTATION_PROCESSING,
    input  logic                    HASH_VALID,
    output logic [0:R_BLOCK_SIZE-1] BLOCK_OUT,
    output logic                    BLOCK_VALID,
    output logic                    BLOCK_LAST
);

    localparam int BLOCK_BYTES = R_BLOCK_SIZE / 8;
    localparam int WORDS       = R_BLOCK_SIZE / Z_WIDTH;
    localparam int CNT_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    pad_state_t              state_reg, state_next;
    logic [CNT_W-1:0]        word_cnt_reg, word_cnt_next;
    logic                    last_reg, last_next;
    logic                    pad_pending_reg, pad_pending_next;
    logic                    block_valid_reg, block_valid_next;
    logic                    block_last_reg, block_last_next;
    logic [0:R_BLOCK_SIZE-1] block_reg, block_next;

    logic                    accept;
    logic                    pad_now;
    logic                    clear_buf;
    logic                    load_pad;
    logic [3:0]              nbytes;
    logic [15:0]             pad_pos;

    assign DATA_READY  = (state_reg == FILL);
    assign BLOCK_OUT   = block_reg;
    assign BLOCK_VALID = block_valid_reg;
    assign BLOCK_LAST  = block_last_reg;

    assign accept  = CE && DATA_VALID && (state_reg == FILL);
    assign nbytes  = DATA_LAST ? clamp_bytes(DATA_BYTES) : 4'd8;
    // Byte position right after the message within the current block.
    assign pad_pos = 16'({word_cnt_reg, 3'b000}) + 16'(nbytes);
    // A pad_pos equal to the block size means the message filled the block
    // exactly, so the padding has to go into an extra block.
    assign pad_now = accept && DATA_LAST && (pad_pos < 16'(BLOCK_BYTES));

    // ------------------------------------------------------------------
    // Control: next state and flag updates
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        word_cnt_next    = word_cnt_reg;
        last_next        = last_reg;
        pad_pending_next = pad_pending_reg;
        block_valid_next = 1'b0;
        block_last_next  = 1'b0;
        clear_buf        = 1'b0;
        load_pad         = 1'b0;

        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (DATA_LAST) begin
                        state_next = SEND;
                        if (pad_now) begin
                            last_next = 1'b1;
                        end else begin
                            pad_pending_next = 1'b1;
                        end
                    end else if (word_cnt_reg == LAST_WORD) begin
                        state_next = SEND;
                    end else begin
                        word_cnt_next = word_cnt_reg + 1'b1;
                    end
                end
            end

            SEND: begin
                if (!PERMUTATION_PROCESSING) begin
                    block_valid_next = 1'b1;
                    block_last_next  = last_reg;
                    if (pad_pending_reg) begin
                        pad_pending_next = 1'b0;
                        state_next       = PAD_BLOCK;
                    end else if (last_reg) begin
                        state_next = WAIT_HASH;
                    end else begin
                        state_next = WAIT_PERM;
                    end
                end
            end

            PAD_BLOCK: begin
                if (!PERMUTATION_PROCESSING) begin
                    load_pad   = 1'b1;
                    last_next  = 1'b1;
                    state_next = SEND;
                end
            end

            WAIT_PERM: begin
                if (!PERMUTATION_PROCESSING) begin
                    clear_buf     = 1'b1;
                    word_cnt_next = '0;
                    state_next    = FILL;
                end
            end

            WAIT_HASH: begin
                if (HASH_VALID) begin
                    clear_buf        = 1'b1;
                    word_cnt_next    = '0;
                    last_next        = 1'b0;
                    pad_pending_next = 1'b0;
                    state_next       = FILL;
                end
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Block buffer: one small update network per byte. The buffer is
    // always zero outside the words written so far, so the zero run of
    // the padding comes for free.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
            localparam int LANE = gi % 8;
            localparam int WIDX = gi / 8;
            localparam logic [7:0] PAD_INIT =
                ((gi == 0) ? PAD_FIRST : 8'h00) |
                ((gi == BLOCK_BYTES - 1) ? PAD_LAST : 8'h00);
            localparam logic IS_TAIL = (gi == BLOCK_BYTES - 1);

            logic [7:0] byte_next;

            always_comb begin
                byte_next = block_reg[8*gi +: 8];
                if (clear_buf) begin
                    byte_next = 8'h00;
                end else if (load_pad) begin
                    byte_next = PAD_INIT;
                end else if (accept) begin
                    if (word_cnt_reg == CNT_W'(WIDX)) begin
                        // Unused bytes of a short final word are zeroed.
                        byte_next = (4'(LANE) < nbytes) ? DATA_IN[8*LANE +: 8] : 8'h00;
                    end
                    if (pad_now && (pad_pos == 16'(gi))) begin
                        byte_next = byte_next | PAD_FIRST;
                    end
                    // OR rather than overwrite, so a message ending at the
                    // second-to-last byte yields 0x86 here.
                    if (pad_now && IS_TAIL) begin
                        byte_next = byte_next | PAD_LAST;
                    end
                end
            end

            assign block_next[8*gi +: 8] = byte_next;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge A_RST) begin
        if (A_RST) begin
            state_reg       <= FILL;
            word_cnt_reg    <= '0;
            last_reg        <= 1'b0;
            pad_pending_reg <= 1'b0;
            block_valid_reg <= 1'b0;
            block_last_reg  <= 1'b0;
            block_reg       <= '0;
        end else if (CE) begin
            state_reg       <= state_next;
            word_cnt_reg    <= word_cnt_next;
            last_reg        <= last_next;
            pad_pending_reg <= pad_pending_next;
            block_valid_reg <= block_valid_next;
            block_last_reg  <= block_last_next;
            block_reg       <= block_next;
        end
    end

endmodule

// File: tb/tb_padding_module.sv
module tb_padding_module;

    localparam int R     = 1152;
    localparam int BYTES = R / 8;

    typedef struct {
        logic [0:R-1] data;
        logic         last;
    } exp_t;

    logic          CLK = 1'b0;
    logic          A_RST;
    logic          CE;
    logic [0:63]   DATA_IN;
    logic          DATA_VALID;
    logic          DATA_LAST;
    logic [3:0]    DATA_BYTES;
    logic          DATA_READY;
    logic          PERMUTATION_PROCESSING;
    logic          HASH_VALID;
    logic [0:R-1]  BLOCK_OUT;
    logic          BLOCK_VALID;
    logic          BLOCK_LAST;

    logic ce_rand, ce_force_low, rand_ce_en;
    logic perm_model, perm_force, perm_idle;
    logic perm_at_edge, ce_at_edge;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    assign CE = ce_rand & ~ce_force_low;
    assign PERMUTATION_PROCESSING = perm_model | perm_force;

    padding_module #(.R_BLOCK_SIZE(R)) dut (
        .CLK                    (CLK),
        .A_RST                  (A_RST),
        .CE                     (CE),
        .DATA_IN                (DATA_IN),
        .DATA_VALID             (DATA_VALID),
        .DATA_LAST              (DATA_LAST),
        .DATA_BYTES             (DATA_BYTES),
        .DATA_READY             (DATA_READY),
        .PERMUTATION_PROCESSING (PERMUTATION_PROCESSING),
        .HASH_VALID             (HASH_VALID),
        .BLOCK_OUT              (BLOCK_OUT),
        .BLOCK_VALID            (BLOCK_VALID),
        .BLOCK_LAST             (BLOCK_LAST)
    );

    always #5 CLK = ~CLK;

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string name, input logic [0:R-1] act, input logic [0:R-1] exp);
        int first;
        checks++;
        if (act !== exp) begin
            errors++;
            first = -1;
            for (int k = BYTES - 1; k >= 0; k--)
                if (act[8*k +: 8] !== exp[8*k +: 8]) first = k;
            $display("FAIL %s: byte %0d got %02h expected %02h (t=%0t)",
                     name, first, act[8*first +: 8], exp[8*first +: 8], $time);
        end
    endtask

    // Reference model: SHA-3 pad10*1 with 0x06 suffix over the byte string,
    // then cut into rate-sized blocks.
    task automatic push_expected(input logic [7:0] msg[$]);
        logic [7:0] p[$];
        exp_t       e;
        int         nblk;
        p = msg;
        p.push_back(8'h06);
        while ((p.size() % BYTES) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nblk = p.size() / BYTES;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int k = 0; k < BYTES; k++) e.data[8*k +: 8] = p[b*BYTES + k];
            e.last = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    // Drives a message word by word; abort_words >= 0 stops early (no expectation).
    task automatic send_msg(input logic [7:0] msg[$], input int abort_words, input bit gaps);
        int len, nwords, n, to;
        bit accepted;
        len    = msg.size();
        nwords = (len == 0) ? 1 : (len + 7) / 8;
        if (abort_words < 0) push_expected(msg);
        for (int i = 0; i < nwords; i++) begin
            if (abort_words >= 0 && i >= abort_words) break;
            if (gaps && $urandom_range(0, 3) == 0) begin
                DATA_VALID = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
            for (int j = 0; j < 8; j++)
                DATA_IN[8*j +: 8] = (8*i + j < len) ? msg[8*i + j] : 8'($urandom);
            n = len - 8*i;
            DATA_LAST  = (i == nwords - 1);
            DATA_BYTES = (i == nwords - 1) ? ((n >= 8) ? 4'($urandom_range(8, 15)) : 4'(n))
                                           : 4'($urandom_range(0, 15));
            DATA_VALID = 1'b1;
            accepted = 0;
            to = 0;
            while (!accepted) begin
                @(negedge CLK);
                if (DATA_READY && CE && !A_RST) begin
                    @(posedge CLK);
                    #1;
                    accepted = 1;
                end else if (++to > 3000) begin
                    errors++; checks++;
                    $display("FAIL word_accept_timeout: word %0d not accepted, required within 3000 cycles", i);
                    break;
                end
            end
        end
        DATA_VALID = 1'b0;
        DATA_LAST  = 1'b0;
    endtask

    task automatic wait_idle();
        int to = 0;
        while (exp_q.size() != 0 || !perm_idle || !DATA_READY) begin
            @(negedge CLK);
            if (++to > 5000) begin
                errors++; checks++;
                $display("FAIL idle_timeout: %0d blocks outstanding, required 0", exp_q.size());
                break;
            end
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK) begin
        perm_at_edge <= PERMUTATION_PROCESSING;
        ce_at_edge   <= CE;
    end

    // Random clock-enable generator.
    initial begin
        ce_rand = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            ce_rand = rand_ce_en ? ($urandom_range(0, 7) != 0) : 1'b1;
        end
    end

    // Monitor / scoreboard: a strobe is consumed on an edge with CE=1.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (BLOCK_VALID && ce_at_edge && !A_RST) begin
                chk_val("strobe_while_busy", 32'(perm_at_edge), 32'd0);
            end
            if (BLOCK_VALID && CE && !A_RST) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_block: strobe seen, required none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk_blk("block_out", BLOCK_OUT, e.data);
                    chk_val("block_last", 32'(BLOCK_LAST), 32'(e.last));
                    $display("block checked: last=%0b outstanding=%0d", BLOCK_LAST, exp_q.size());
                end
            end
        end
    end

    // Permutation stand-in: busy for a random time after each block,
    // then a digest indication after a final block.
    initial begin
        logic was_last;
        int   to;
        perm_model = 1'b0;
        HASH_VALID = 1'b0;
        perm_idle  = 1'b1;
        forever begin
            @(negedge CLK);
            if (BLOCK_VALID && CE && !A_RST) begin
                perm_idle = 1'b0;
                was_last  = BLOCK_LAST;
                @(posedge CLK);
                #1;
                perm_model = 1'b1;
                repeat ($urandom_range(1, 30)) @(posedge CLK);
                #1;
                perm_model = 1'b0;
                if (was_last) begin
                    HASH_VALID = 1'b1;
                    to = 0;
                    do begin
                        @(negedge CLK);
                        to++;
                    end while (!DATA_READY && to < 1000);
                    if (!DATA_READY) begin
                        errors++; checks++;
                        $display("FAIL hash_release: DATA_READY=0, required 1 after HASH_VALID");
                    end
                    HASH_VALID = 1'b0;
                end
                perm_idle = 1'b1;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m[$];
        int len;

        A_RST = 1'b1; ce_force_low = 1'b0; rand_ce_en = 1'b0; perm_force = 1'b0;
        DATA_IN = '0; DATA_VALID = 1'b0; DATA_LAST = 1'b0; DATA_BYTES = 4'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        A_RST = 1'b0;
        @(negedge CLK);
        chk_val("reset_ready", 32'(DATA_READY), 32'd1);
        chk_val("reset_valid", 32'(BLOCK_VALID), 32'd0);
        chk_val("reset_last", 32'(BLOCK_LAST), 32'd0);
        chk_blk("reset_block", BLOCK_OUT, '0);
        @(posedge CLK); #1;

        // Empty message, with one-cycle latency check.
        m = {};
        send_msg(m, -1, 0);
        @(posedge CLK); #1;
        chk_val("latency_empty", 32'(BLOCK_VALID), 32'd1);
        wait_idle();

        // "abc"
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, -1, 0);
        @(posedge CLK); #1;
        chk_val("latency_abc", 32'(BLOCK_VALID), 32'd1);
        wait_idle();

        // 143 and 144 byte boundaries.
        m = {};
        for (int i = 0; i < 143; i++) m.push_back(8'($urandom));
        send_msg(m, -1, 1);
        wait_idle();
        m.push_back(8'($urandom));
        send_msg(m, -1, 1);
        wait_idle();

        // Permutation held busy during SEND, then a CE stall.
        perm_force = 1'b1;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, -1, 0);
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            chk_val("busy_no_strobe", 32'(BLOCK_VALID), 32'd0);
            chk_val("busy_not_ready", 32'(DATA_READY), 32'd0);
        end
        ce_force_low = 1'b1;
        perm_force   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            chk_val("ce_stall_strobe", 32'(BLOCK_VALID), 32'd0);
            chk_blk("ce_stall_block", BLOCK_OUT, exp_q[0].data);
        end
        @(posedge CLK); #1;
        ce_force_low = 1'b0;
        wait_idle();

        // Reset after 5 of 18 words discards the message.
        m = {};
        for (int i = 0; i < 144; i++) m.push_back(8'($urandom_range(1, 255)));
        send_msg(m, 5, 0);
        @(negedge CLK);
        #2 A_RST = 1'b1;
        #1;
        chk_val("midrst_valid", 32'(BLOCK_VALID), 32'd0);
        chk_val("midrst_last", 32'(BLOCK_LAST), 32'd0);
        chk_blk("midrst_block", BLOCK_OUT, '0);
        chk_val("midrst_ready", 32'(DATA_READY), 32'd1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        A_RST = 1'b0;
        @(posedge CLK); #1;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, -1, 0);
        wait_idle();

        // Randomized messages with random CE and permutation timing.
        rand_ce_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 5))
                0: len = $urandom_range(0, 16);
                1: len = 143;
                2: len = 144;
                3: len = $urandom_range(130, 160);
                4: len = $urandom_range(280, 300);
                default: len = $urandom_range(0, 450);
            endcase
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            $display("message %0d: %0d bytes", t, len);
            send_msg(m, -1, 1);
        end
        wait_idle();
        rand_ce_en = 1'b0;
        wait_idle();
        chk_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
